// File: rtl/fb_pkg.sv
// fb_pkg: shared state encoding, frame geometry default and bank identifiers for the frame-buffer scheduler
package fb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_READY} fb_state_e;
  localparam int FRAME_PIXELS = 57600;
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;
endpackage

// File: rtl/fb_wr_addr_gen.sv
// fb_wr_addr_gen: RX pixel address counter; restarts at 0 on start and flags the last pixel of a frame
//  ports: clk, xrst (async active-low); start (accepted SOF), acc (pixel accepted this cycle);
//         addr (address of the pixel accepted this cycle), last (pixel FRAME_PIXELS-1 accepted)
module fb_wr_addr_gen #(
  parameter int FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  input  logic              acc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  logic [ADDR_W-1:0] pix_cnt;
  assign addr = start ? '0 : pix_cnt;
  assign last = acc && addr == LAST_ADDR;
  // the counter clears after the last pixel instead of stepping past the frame
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) pix_cnt <= '0;
    else if (acc) pix_cnt <= last ? '0 : addr + 1'b1;
    else if (start) pix_cnt <= '0;
endmodule

// File: rtl/fb_bank_scheduler.sv
// fb_bank_scheduler: double-buffer scheduler; RX fills one bank, scan-out reads the other, swap on vsync
//  ports: clk, xrst (async active-low); wr_sof/wr_valid/wr_data RX stream; bram_we/bram_waddr/bram_wdata
//         bank writes; rd_vd vsync; rd_data_a/rd_data_b bank reads; rd_data muxed read; rd_bank/wr_bank;
//         frame_ready, swap_pulse; drop_cnt only when FB_DROP_CNT_EN is defined
module fb_bank_scheduler
  import fb_pkg::*;
#(
  parameter int FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24,
  parameter bit VS_POL = 1'b1
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              wr_sof,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic [1:0]        bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic              rd_vd,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_bank,
  output logic              wr_bank,
  output logic              frame_ready,
  output logic              swap_pulse
`ifdef FB_DROP_CNT_EN
  ,output logic [15:0]      drop_cnt
`endif
);
  fb_state_e state, next_state;
  logic vs_d, vs_edge, start, acc, last, swap, rd_bank_d;
  logic [ADDR_W-1:0] addr;
  assign wr_bank = ~rd_bank;
  // a READY frame is never overwritten, so SOF only starts a frame outside READY
  assign start = wr_sof && state != ST_READY;
  assign acc = wr_valid && (start || state == ST_FILL);
  assign vs_edge = rd_vd == VS_POL && vs_d != VS_POL;
  assign swap = state == ST_READY && vs_edge;
  // select delayed by one clock to line up with the BRAM read latency
  assign rd_data = rd_bank_d ? rd_data_b : rd_data_a;
  fb_wr_addr_gen #(.FRAME_PIXELS(FRAME_PIXELS), .ADDR_W(ADDR_W)) u_addr (
    .clk(clk), .xrst(xrst), .start(start), .acc(acc), .addr(addr), .last(last)
  );
  always_comb begin
    next_state = state;
    next_state = (start || state == ST_FILL) ? (last ? ST_READY : ST_FILL) : swap ? ST_IDLE : state;
  end
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      state       <= ST_IDLE;
      vs_d        <= !VS_POL;
      bram_we     <= 2'b00;
      bram_waddr  <= '0;
      bram_wdata  <= '0;
      rd_bank     <= BANK_A;
      rd_bank_d   <= BANK_A;
      frame_ready <= 1'b0;
      swap_pulse  <= 1'b0;
    end else begin
      state       <= next_state;
      vs_d        <= rd_vd;
      bram_we     <= acc ? (wr_bank == BANK_B ? 2'b10 : 2'b01) : 2'b00;
      bram_waddr  <= acc ? addr : bram_waddr;
      bram_wdata  <= acc ? wr_data : bram_wdata;
      rd_bank     <= swap ? wr_bank : rd_bank;
      rd_bank_d   <= rd_bank;
      frame_ready <= next_state == ST_READY;
      swap_pulse  <= swap;
    end
`ifdef FB_DROP_CNT_EN
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) drop_cnt <= '0;
    else if (wr_sof && state != ST_IDLE && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_fb_bank_scheduler.sv
// tb_fb_bank_scheduler: directed checks of fill, swap, restart, READY protection and async reset
module tb_fb_bank_scheduler;
  localparam int FP = 64;
  logic clk, xrst, wr_sof, wr_valid, rd_vd;
  logic [23:0] wr_data, rd_data_a, rd_data_b, rd_data, dat, cur;
  logic [1:0] bram_we;
  logic [17:0] bram_waddr;
  logic [23:0] bram_wdata;
  logic rd_bank, wr_bank, frame_ready, swap_pulse;
  int vecs = 0, errs = 0;
`ifdef FB_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  fb_bank_scheduler #(.FRAME_PIXELS(FP), .ADDR_W(18), .DATA_W(24), .VS_POL(1'b1)) dut (
    .clk(clk), .xrst(xrst), .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_data(wr_data),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata), .rd_vd(rd_vd),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data(rd_data), .rd_bank(rd_bank),
    .wr_bank(wr_bank), .frame_ready(frame_ready), .swap_pulse(swap_pulse)
`ifdef FB_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic s, input logic v, input logic d);
    cur = dat;
    dat = dat + 24'h010203;
    wr_sof = s;
    wr_valid = v;
    rd_vd = d;
    wr_data = cur;
    @(negedge clk);
  endtask
  task automatic pix(input logic s, input logic d, input int a, input logic [1:0] we);
    step(s, 1'b1, d);
    chk("we", 32'(bram_we), 32'(we));
    chk("waddr", 32'(bram_waddr), 32'(a));
    chk("wdata", 32'(bram_wdata), 32'(cur));
  endtask
  initial begin
    xrst = 1'b0; wr_sof = 1'b0; wr_valid = 1'b0; rd_vd = 1'b0; wr_data = '0;
    dat = 24'hA50001; cur = '0;
    rd_data_a = 24'h111111; rd_data_b = 24'h222222;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(bram_we), 0);
    chk("rst_waddr", 32'(bram_waddr), 0);
    chk("rst_wdata", 32'(bram_wdata), 0);
    chk("rst_rd_bank", 32'(rd_bank), 0);
    chk("rst_wr_bank", 32'(wr_bank), 1);
    chk("rst_ready", 32'(frame_ready), 0);
    chk("rst_swap", 32'(swap_pulse), 0);
`ifdef FB_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt), 0);
`endif
    xrst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    chk("idle_ignore_we", 32'(bram_we), 0);
    chk("rd_data_a", 32'(rd_data), 32'(rd_data_a));
    for (int i = 0; i < FP; i++) begin
      pix(i == 0, 1'b0, i, 2'b10);
      if (i == FP - 2) chk("f1_not_ready", 32'(frame_ready), 0);
    end
    chk("f1_ready", 32'(frame_ready), 1);
    chk("f1_rd_bank", 32'(rd_bank), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("ready_ignore_we", 32'(bram_we), 0);
    step(1'b0, 1'b0, 1'b1);
    chk("swap1_pulse", 32'(swap_pulse), 1);
    chk("swap1_rd_bank", 32'(rd_bank), 1);
    chk("swap1_wr_bank", 32'(wr_bank), 0);
    chk("swap1_ready", 32'(frame_ready), 0);
    chk("rd_data_delay", 32'(rd_data), 32'(rd_data_a));
    step(1'b0, 1'b0, 1'b1);
    chk("swap1_pulse_end", 32'(swap_pulse), 0);
    chk("rd_data_b", 32'(rd_data), 32'(rd_data_b));
    for (int i = 0; i < FP; i++) begin
      pix(i == 0, (i >= 10 && i < FP - 2) || i == FP - 1, i, 2'b01);
      if (i == 10) begin
        chk("midfill_no_swap", 32'(swap_pulse), 0);
        chk("midfill_rd_bank", 32'(rd_bank), 1);
      end
    end
    chk("f2_ready", 32'(frame_ready), 1);
    chk("f2_last_vs_no_swap", 32'(swap_pulse), 0);
    chk("f2_rd_bank", 32'(rd_bank), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("vs_held_no_swap", 32'(swap_pulse), 0);
    chk("vs_held_ready", 32'(frame_ready), 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("swap2_pulse", 32'(swap_pulse), 1);
    chk("swap2_rd_bank", 32'(rd_bank), 0);
    chk("swap2_wr_bank", 32'(wr_bank), 1);
    for (int i = 0; i < 30; i++) pix(i == 0, 1'b0, i, 2'b10);
    pix(1'b1, 1'b0, 0, 2'b10);
    for (int i = 1; i < FP; i++) pix(1'b0, 1'b0, i, 2'b10);
    chk("f3_ready", 32'(frame_ready), 1);
`ifdef FB_DROP_CNT_EN
    chk("drop_restart", 32'(drop_cnt), 1);
`endif
    step(1'b1, 1'b1, 1'b0);
    chk("ready_sof_we", 32'(bram_we), 0);
    chk("ready_sof_ready", 32'(frame_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("ready_pix_we", 32'(bram_we), 0);
    end
`ifdef FB_DROP_CNT_EN
    chk("drop_ready", 32'(drop_cnt), 2);
`endif
    step(1'b0, 1'b0, 1'b1);
    chk("swap3_pulse", 32'(swap_pulse), 1);
    chk("swap3_rd_bank", 32'(rd_bank), 1);
    for (int i = 0; i < 20; i++) pix(i == 0, 1'b0, i, 2'b01);
    #2 xrst = 1'b0;
    #1;
    chk("arst_we", 32'(bram_we), 0);
    chk("arst_waddr", 32'(bram_waddr), 0);
    chk("arst_wdata", 32'(bram_wdata), 0);
    chk("arst_rd_bank", 32'(rd_bank), 0);
    chk("arst_wr_bank", 32'(wr_bank), 1);
    chk("arst_ready", 32'(frame_ready), 0);
`ifdef FB_DROP_CNT_EN
    chk("arst_drop", 32'(drop_cnt), 0);
`endif
    wr_sof = 1'b0; wr_valid = 1'b0; rd_vd = 1'b0;
    @(negedge clk);
    xrst = 1'b1;
    pix(1'b1, 1'b0, 0, 2'b10);
    pix(1'b0, 1'b0, 1, 2'b10);
    chk("post_rst_ready", 32'(frame_ready), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
